// File: rtl/alu_pkg.sv
// Shared constants for the ID/EX issue stage: ALU control codes, RV32I
// opcodes, funct3 values, immediate format tags and the funct3->ALU map.
package alu_pkg;

  // ALU control codes driven onto the ALUControl bus
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SRA  = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SLT  = 4'b0110;
  localparam logic [3:0] ALU_SLTU = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b1001;

  // RV32I major opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // funct3 for OP / OP-IMM
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  // funct3 for BRANCH
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // funct7 values that are legal on OP / shift-immediate
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Immediate encodings selected by opcode
  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  // Register/immediate arithmetic: funct3 picks the op, alt picks sub/sra
  function automatic logic [3:0] alu_code(input logic [2:0] f3, input logic alt);
    logic [3:0] code;
    case (f3)
      F3_ADD_SUB: code = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:     code = ALU_SLL;
      F3_SLT:     code = ALU_SLT;
      F3_SLTU:    code = ALU_SLTU;
      F3_XOR:     code = ALU_XOR;
      F3_SR:      code = alt ? ALU_SRA : ALU_SRL;
      F3_OR:      code = ALU_OR;
      F3_AND:     code = ALU_AND;
      default:    code = ALU_ADD;
    endcase
    return code;
  endfunction

  // Branch compare: equality via sub (Zero), ordering via slt/sltu
  function automatic logic [3:0] branch_code(input logic [2:0] f3);
    logic [3:0] code;
    case (f3)
      F3_BEQ, F3_BNE:   code = ALU_SUB;
      F3_BLT, F3_BGE:   code = ALU_SLT;
      F3_BLTU, F3_BGEU: code = ALU_SLTU;
      default:          code = ALU_SUB;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate extraction; the format is chosen from the
// opcode so the caller gets the one immediate that instruction carries.
module imm_gen
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm
);

  imm_fmt_e fmt;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Classify the opcode into an immediate format
  always_comb begin
    case (instr[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: fmt = IMM_I;
      OPC_STORE:                      fmt = IMM_S;
      OPC_BRANCH:                     fmt = IMM_B;
      OPC_LUI, OPC_AUIPC:             fmt = IMM_U;
      OPC_JAL:                        fmt = IMM_J;
      default:                        fmt = IMM_NONE;
    endcase
  end

  // Pick the immediate for that format
  always_comb begin
    case (fmt)
      IMM_I:   imm = imm_i;
      IMM_S:   imm = imm_s;
      IMM_B:   imm = imm_b;
      IMM_U:   imm = imm_u;
      IMM_J:   imm = imm_j;
      default: imm = 32'b0;
    endcase
  end

endmodule

// File: rtl/alu_op_issue.sv
// ID-to-EX issue stage: decodes one RV32I instruction into ALU control,
// selects operands A/B and holds them in a one-entry ID/EX buffer with
// valid/ready handshake, stall and flush.
// Optional build macro ILLEGAL_TRAP_EN adds out_illegal and suppresses
// writeback of illegal encodings.
module alu_op_issue
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RF_AW = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_a,
  output logic [XLEN-1:0]  out_b,
  output logic [3:0]       out_alu_control,
  output logic [RF_AW-1:0] out_rd,
  output logic             out_reg_write,
  output logic             out_is_branch,
`ifdef ILLEGAL_TRAP_EN
  output logic             out_illegal,
`endif
  output logic [2:0]       out_funct3
);

  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [RF_AW-1:0] rd_field;
  logic [31:0]      imm;

  logic [XLEN-1:0]  a_next, b_next;
  logic [3:0]       alu_next;
  logic             reg_write_dec;
  logic             reg_write_next;
  logic             is_branch_next;

  logic             valid_reg;
  logic [XLEN-1:0]  a_reg, b_reg;
  logic [3:0]       alu_reg;
  logic [RF_AW-1:0] rd_reg;
  logic             reg_write_reg;
  logic             is_branch_reg;
  logic [2:0]       funct3_reg;
  logic             accept;

  assign opcode   = in_instr[6:0];
  assign funct3   = in_instr[14:12];
  assign funct7   = in_instr[31:25];
  assign rd_field = in_instr[7 +: RF_AW];

  imm_gen u_imm_gen (
    .instr (in_instr),
    .imm   (imm)
  );

  // Decode opcode/funct fields into ALU code, operands and writeback enable
  always_comb begin
    alu_next       = ALU_ADD;
    a_next         = '0;
    b_next         = '0;
    reg_write_dec  = 1'b0;
    is_branch_next = 1'b0;
    case (opcode)
      OPC_OP: begin
        alu_next      = alu_code(funct3, in_instr[30]);
        a_next        = rs1_data;
        b_next        = rs2_data;
        reg_write_dec = 1'b1;
      end
      OPC_OP_IMM: begin
        // only srai uses funct7[5]; shifts take the raw 5-bit shamt
        alu_next      = alu_code(funct3, (funct3 == F3_SR) && in_instr[30]);
        a_next        = rs1_data;
        b_next        = (funct3 == F3_SLL || funct3 == F3_SR) ? XLEN'(in_instr[24:20]) : imm;
        reg_write_dec = 1'b1;
      end
      OPC_LOAD: begin
        a_next        = rs1_data;
        b_next        = imm;
        reg_write_dec = 1'b1;
      end
      OPC_STORE: begin
        a_next = rs1_data;
        b_next = imm;
      end
      OPC_LUI: begin
        b_next        = imm;
        reg_write_dec = 1'b1;
      end
      OPC_AUIPC: begin
        a_next        = in_pc;
        b_next        = imm;
        reg_write_dec = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        // the ALU produces the link value pc+4
        a_next        = in_pc;
        b_next        = XLEN'(4);
        reg_write_dec = 1'b1;
      end
      OPC_BRANCH: begin
        alu_next       = branch_code(funct3);
        a_next         = rs1_data;
        b_next         = rs2_data;
        is_branch_next = 1'b1;
      end
      default: begin
        // unknown opcode: bubble (add, no writeback)
      end
    endcase
    if (rd_field == '0) begin
      reg_write_dec = 1'b0;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_next;
  logic illegal_reg;

  // Flag unknown opcodes and funct7 values outside the defined encodings
  always_comb begin
    illegal_next = 1'b0;
    case (opcode)
      OPC_OP: begin
        illegal_next = !((funct7 == F7_BASE) ||
                         (funct7 == F7_ALT && (funct3 == F3_ADD_SUB || funct3 == F3_SR)));
      end
      OPC_OP_IMM: begin
        if (funct3 == F3_SLL) begin
          illegal_next = (funct7 != F7_BASE);
        end else if (funct3 == F3_SR) begin
          illegal_next = (funct7 != F7_BASE) && (funct7 != F7_ALT);
        end
      end
      OPC_LOAD, OPC_STORE, OPC_LUI, OPC_AUIPC,
      OPC_JAL, OPC_JALR, OPC_BRANCH: illegal_next = 1'b0;
      default: illegal_next = 1'b1;
    endcase
  end

  assign reg_write_next = reg_write_dec && !illegal_next;
  assign out_illegal    = illegal_reg;
`else
  assign reg_write_next = reg_write_dec;
`endif

  // Room for a new op when the slot is empty, being drained, or being flushed
  assign in_ready = flush || !valid_reg || out_ready;
  assign accept   = in_valid && in_ready;

  // ID/EX buffer: reset > flush > accept > drain
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg     <= 1'b0;
      a_reg         <= '0;
      b_reg         <= '0;
      alu_reg       <= ALU_ADD;
      rd_reg        <= '0;
      reg_write_reg <= 1'b0;
      is_branch_reg <= 1'b0;
      funct3_reg    <= '0;
`ifdef ILLEGAL_TRAP_EN
      illegal_reg   <= 1'b0;
`endif
    end else if (flush) begin
      valid_reg <= 1'b0;
    end else if (accept) begin
      valid_reg     <= 1'b1;
      a_reg         <= a_next;
      b_reg         <= b_next;
      alu_reg       <= alu_next;
      rd_reg        <= rd_field;
      reg_write_reg <= reg_write_next;
      is_branch_reg <= is_branch_next;
      funct3_reg    <= funct3;
`ifdef ILLEGAL_TRAP_EN
      illegal_reg   <= illegal_next;
`endif
    end else if (out_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign out_valid       = valid_reg;
  assign out_a           = a_reg;
  assign out_b           = b_reg;
  assign out_alu_control = alu_reg;
  assign out_rd          = rd_reg;
  assign out_reg_write   = reg_write_reg;
  assign out_is_branch   = is_branch_reg;
  assign out_funct3      = funct3_reg;

endmodule
